// File: rtl/error_locator_par.sv
// Parallel Chien-search back end: consumes L locator evaluations per beat, flags
// zero evaluations as error positions and packs their indices into a list.
module error_locator_par #(
  parameter int m = 13,
  parameter int n = 6960,
  parameter int t = 119,
  parameter int L = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 eva_valid,
  output logic                 eva_ready,
  input  logic [L*m-1:0]       eva_data,
  output logic [n-1:0]         error_recovered,
  output logic [m*t-1:0]       idx_list,
  output logic [$clog2(t):0]   error_hamming_weight,
  output logic                 overflow,
  output logic                 weight_ok,
  output logic                 busy,
  output logic                 done
);

  localparam int WW = $clog2(t) + 1;
  localparam int B  = (n + L - 1) / L;
  localparam int BW = (B > 1) ? $clog2(B) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t          state;
  logic [BW-1:0]   beat_cnt;
  logic [1:0]      rst_pipe;
  logic            rst_sync_n;

  logic [L-1:0]    lane_zero;
  logic [m-1:0]    lane_pos [L];
  logic [n-1:0]    er_next;
  logic [m*t-1:0]  idx_next;
  logic [WW-1:0]   wt_next;
  logic            ovf_next;

  // Reset asserts immediately but releases two edges later, so the FSM never
  // sees a partially released reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_pipe <= 2'b00;
    else        rst_pipe <= {rst_pipe[0], 1'b1};
  end
  assign rst_sync_n = rst_pipe[1];

  // Lanes past the end of the code on the final beat are masked off here.
  for (genvar k = 0; k < L; k++) begin : g_lane
    assign lane_pos[k]  = m'(int'(beat_cnt) * L + k);
    assign lane_zero[k] = ((int'(beat_cnt) * L + k) < n) && (eva_data[m*k +: m] == '0);
  end

  for (genvar j = 0; j < n; j++) begin : g_er
    assign er_next[j] = (beat_cnt == BW'(j / L)) ? lane_zero[j % L] : error_recovered[j];
  end

  // Prefix count over lanes: roots are appended in ascending lane order.
  always_comb begin
    int cnt;
    idx_next = idx_list;
    ovf_next = overflow;
    cnt      = int'(error_hamming_weight);
    for (int k = 0; k < L; k++) begin
      if (lane_zero[k]) begin
        if (cnt < t) begin
          idx_next[m*cnt +: m] = lane_pos[k];
          cnt = cnt + 1;
        end else begin
          ovf_next = 1'b1;
        end
      end
    end
    wt_next = WW'(cnt);
  end

  always_ff @(posedge clk or negedge rst_sync_n) begin
    if (!rst_sync_n) begin
      state                <= IDLE;
      beat_cnt             <= '0;
      error_recovered      <= '0;
      idx_list             <= '0;
      error_hamming_weight <= '0;
      overflow             <= 1'b0;
    end else if (start) begin
      state                <= SCAN;
      beat_cnt             <= '0;
      error_recovered      <= '0;
      idx_list             <= '0;
      error_hamming_weight <= '0;
      overflow             <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (eva_valid) begin
            error_recovered      <= er_next;
            idx_list             <= idx_next;
            error_hamming_weight <= wt_next;
            overflow             <= ovf_next;
            if (beat_cnt == BW'(B - 1)) begin
              state    <= DONE;
              beat_cnt <= '0;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign eva_ready = (state == SCAN);
  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign weight_ok = (state != SCAN) && (error_hamming_weight == WW'(t)) && !overflow;

endmodule

// File: tb/tb_error_locator_par.sv
// Directed bench for error_locator_par (m=5, n=18, t=4, L=4) with a per-cycle
// behavioural model and literal spot checks.
module tb_error_locator_par;
  localparam int M  = 5;
  localparam int N  = 18;
  localparam int T  = 4;
  localparam int LN = 4;
  localparam int B  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              eva_valid = 1'b0;
  logic [LN*M-1:0]   eva_data = '0;
  logic              eva_ready;
  logic [N-1:0]      error_recovered;
  logic [M*T-1:0]    idx_list;
  logic [2:0]        weight;
  logic              overflow, weight_ok, busy, done;

  error_locator_par #(.m(M), .n(N), .t(T), .L(LN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .eva_valid(eva_valid),
    .eva_ready(eva_ready), .eva_data(eva_data),
    .error_recovered(error_recovered), .idx_list(idx_list),
    .error_hamming_weight(weight), .overflow(overflow),
    .weight_ok(weight_ok), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 scanning, 2 done cycle.
  logic [N-1:0] m_er = '0;
  int           m_list[$];
  bit           m_ovf = 1'b0;
  int           m_state = 0;
  int           m_beat = 0;
  int           m_rel = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_er = '0; m_list.delete(); m_ovf = 1'b0; m_state = 0; m_beat = 0; m_rel = 0;
    end else if (m_rel < 2) begin
      m_rel++;
    end else if (start) begin
      m_er = '0; m_list.delete(); m_ovf = 1'b0; m_state = 1; m_beat = 0;
    end else if (m_state == 1) begin
      if (eva_valid) begin
        for (int k = 0; k < LN; k++) begin
          int p;
          p = m_beat * LN + k;
          if (p < N) begin
            m_er[p] = (eva_data[M*k +: M] == '0);
            if (eva_data[M*k +: M] == '0) begin
              if (m_list.size() < T) m_list.push_back(p);
              else m_ovf = 1'b1;
            end
          end
        end
        if (m_beat == B - 1) m_state = 2;
        else m_beat++;
      end
    end else if (m_state == 2) begin
      m_state = 0;
    end
  end

  always @(negedge clk) begin
    logic [M*T-1:0] e_idx;
    e_idx = '0;
    for (int i = 0; i < m_list.size(); i++) e_idx[M*i +: M] = M'(m_list[i]);
    chk("cyc_error_recovered", error_recovered, m_er);
    chk("cyc_idx_list", idx_list, e_idx);
    chk("cyc_weight", weight, m_list.size());
    chk("cyc_overflow", overflow, m_ovf);
    chk("cyc_busy", busy, m_state == 1);
    chk("cyc_eva_ready", eva_ready, m_state == 1);
    chk("cyc_done", done, m_state == 2);
    if (m_state != 1) chk("cyc_weight_ok", weight_ok, (m_list.size() == T) && !m_ovf);
  end

  function automatic logic [LN*M-1:0] beat_data(input logic [19:0] mask, input int b, input int salt);
    logic [LN*M-1:0] d;
    for (int k = 0; k < LN; k++) begin
      int p;
      p = b * LN + k;
      d[M*k +: M] = mask[p] ? 5'd0 : 5'(((p * 7 + salt) % 31) + 1);
    end
    return d;
  endfunction

  task automatic begin_scan();
    start = 1'b1; eva_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge right after the last accepted beat.
  task automatic send_beats(input logic [19:0] mask, input int first, input int cnt, input bit rnd);
    int b; int guard; bit acc;
    b = first; guard = 0;
    while (b < first + cnt && guard < 200) begin
      eva_data  = beat_data(mask, b, guard);
      eva_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = eva_valid && eva_ready;
      @(negedge clk);
      if (acc) b++;
      guard++;
    end
    eva_valid = 1'b0;
    chk("beats_accepted", b, first + cnt);
  endtask

  task automatic full_scan(input logic [19:0] mask, input bit rnd);
    begin_scan();
    send_beats(mask, 0, B, rnd);
    chk("done_after_last_beat", done, 1'b1);
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  task automatic expect_final(input string tag, input logic [N-1:0] er, input logic [M*T-1:0] idx,
                              input int w, input bit ovf, input bit ok);
    chk({tag, "_er"}, error_recovered, er);
    chk({tag, "_idx"}, idx_list, idx);
    chk({tag, "_weight"}, weight, w);
    chk({tag, "_overflow"}, overflow, ovf);
    chk({tag, "_weight_ok"}, weight_ok, ok);
  endtask

  initial begin
    int seen;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    expect_final("reset", '0, '0, 0, 1'b0, 1'b0);
    chk("reset_busy", busy, 1'b0);

    // Roots 1, 6, 17
    full_scan(20'h20042, 1'b0);
    expect_final("roots_1_6_17", 18'h20042, 20'h044C1, 3, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_after_done", idx_list, 20'h044C1);

    // Four roots in beat 0, stored in one cycle
    begin_scan();
    send_beats(20'h0000F, 0, 1, 1'b0);
    chk("beat0_weight", weight, 4);
    send_beats(20'h0000F, 1, B - 1, 1'b0);
    @(negedge clk);
    expect_final("roots_0_3", 18'h0000F, 20'h18820, 4, 1'b0, 1'b1);

    // Five roots: overflow
    full_scan(20'h00AA4, 1'b0);
    expect_final("overflow", 18'h00AA4, 20'h49CA2, 4, 1'b1, 1'b0);

    // Zeros beyond n on the last beat are ignored
    full_scan(20'hD0000, 1'b0);
    expect_final("tail_lanes", 18'h10000, 20'h00010, 1, 1'b0, 1'b0);

    // Random stalls
    full_scan(20'h20042, 1'b1);
    expect_final("stalled", 18'h20042, 20'h044C1, 3, 1'b0, 1'b0);

    // Restart after beat 2, start coincident with a valid beat
    begin_scan();
    send_beats(20'h00AA4, 0, 3, 1'b0);
    chk("pre_restart_overflow", overflow, 1'b1);
    start = 1'b1; eva_valid = 1'b1; eva_data = beat_data(20'h00AA4, 3, 0);
    @(negedge clk);
    start = 1'b0; eva_valid = 1'b0;
    chk("restart_weight", weight, 0);
    chk("restart_overflow", overflow, 1'b0);
    chk("restart_er", error_recovered, 18'h0);
    send_beats(20'h01008, 0, B, 1'b1);
    chk("restart_done", done, 1'b1);
    @(negedge clk);
    expect_final("restart", 18'h01008, 20'h00183, 2, 1'b0, 1'b0);

    // Reset mid-scan
    begin_scan();
    send_beats(20'h0000F, 0, 2, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_weight", weight, 0);
    chk("async_rst_er", error_recovered, 18'h0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", eva_ready, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    chk("idle_after_reset", busy, 1'b0);

    full_scan(20'h00400, 1'b0);
    expect_final("after_reset", 18'h00400, 20'h0000A, 1, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
